// File: rtl/alu_seq_stage.sv
// alu_seq_stage: registered N-bit ALU stage with a valid/ready handshake on
// both sides. It accepts one operation at a time. ADD, SUB, AND, OR, XOR and
// NOT finish at the acceptance edge. SLL and SRL shift one bit per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   in_valid   request present
//   in_ready   stage can accept (IDLE only)
//   op         0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL, 7 SRL
//   A, B       operands; shifts use only B[SW-1:0] as the amount
//   out_valid  result available (DONE only)
//   out_ready  downstream accepts the result
//   result     registered result
//   carry      registered carry / last bit shifted out
//   zero       registered flag, set when result == 0
module alu_seq_stage #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] cnt;
    logic          shl_q;        // direction of the shift in flight
    logic [N:0]    eval;         // {carry, result} of a single-cycle op
    logic [N-1:0]  sh_next;      // result after one more shift step
    logic          sh_out;       // bit leaving the register on this step
    logic          is_shift;
    logic          accept;

    // Single-cycle ops, built from the inverter, bitwise gates and adder.
    // Subtraction is A + ~B + 1, so carry = 1 means no borrow. Shifts return
    // A unchanged with carry 0: that is the loaded value before shifting.
    function automatic logic [N:0] alu_eval(input logic [2:0]   f,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N-1:0] b_inv;
        logic [N:0]   r;
        b_inv = ~b;
        case (f)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} + {1'b0, b_inv} + (N+1)'(1);
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_NOT:  r = {1'b0, ~a};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign is_shift  = (op == OP_SLL) || (op == OP_SRL);
    assign accept    = in_valid && (state == IDLE);
    assign eval      = alu_eval(op, A, B);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        sh_next = result;
        sh_out  = 1'b0;
        if (shl_q) begin
            sh_next = {result[N-2:0], 1'b0};
            sh_out  = result[N-1];
        end else begin
            sh_next = {1'b0, result[N-1:1]};
            sh_out  = result[0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    // A shift by zero has nothing to do and completes at once.
                    if (is_shift && (B[SW-1:0] != '0))
                        state_nxt = BUSY;
                    else
                        state_nxt = DONE;
                end
            end
            BUSY: begin
                if (cnt == SW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shl_q  <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // The result register doubles as the shift register.
                result <= eval[N-1:0];
                carry  <= eval[N];
                zero   <= (eval[N-1:0] == '0);
                shl_q  <= (op == OP_SLL);
                cnt    <= is_shift ? B[SW-1:0] : '0;
            end else if (state == BUSY) begin
                result <= sh_next;
                carry  <= sh_out;
                zero   <= (sh_next == '0);
                cnt    <= cnt - SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_stage.sv
module tb_alu_seq_stage;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carry;
    logic         zero;

    int n_vec;
    int n_bad;

    alu_seq_stage #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         cy;
        logic         zf;
        int           lat;   // edges from acceptance (inclusive) to out_valid
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present a request for one acceptance edge, then
    // scramble the inputs so late changes would corrupt a non-captured result.
    task automatic issue(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = f;
        A  = a;
        B  = b;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7));
        A  = N'($urandom);
        B  = N'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        logic rdy_err;
        issue(v.op, v.a, v.b);
        lat = 1;
        rdy_err = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_err = 1'b1;
            tick();
            lat++;
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_latency"},   32'(lat),       32'(v.lat));
        chk({tag, "_busy_ready"}, 32'(rdy_err),  32'd0);
        chk({tag, "_result"},    32'(result),    32'(v.res));
        chk({tag, "_carry"},     32'(carry),     32'(v.cy));
        chk({tag, "_zero"},      32'(zero),      32'(v.zf));
        // out_ready is high here, so the next edge completes the handshake.
        tick();
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        A         = '0;
        B         = '0;
        out_ready = 1'b1;

        //          op    A      B      result cy zf lat
        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1};
        vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1};
        vecs[2]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'd5, 8'hA5, 8'h33, 8'h5A, 1'b0, 1'b0, 1};
        vecs[4]  = '{3'd4, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'd3, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'd6, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 4};
        vecs[8]  = '{3'd7, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 2};
        vecs[9]  = '{3'd6, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1};
        vecs[10] = '{3'd7, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 8};
        vecs[11] = '{3'd6, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 8};
        vecs[12] = '{3'd7, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 2};
        vecs[13] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1};
        vecs[14] = '{3'd6, 8'hC0, 8'h02, 8'h00, 1'b1, 1'b1, 3};
        vecs[15] = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1};

        // Reset state
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_carry",     32'(carry),     32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: DONE holds while a new request waits upstream.
        out_ready = 1'b0;
        issue(3'd0, 8'h10, 8'h20);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        op = 3'd1;
        A  = 8'h09;
        B  = 8'h04;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_result",    32'(result),    32'h30);
            chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle_in_ready",  32'(in_ready),  32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_new_out_valid", 32'(out_valid), 32'd1);
        chk("bp_new_result",    32'(result),    32'h05);
        chk("bp_new_carry",     32'(carry),     32'd1);
        tick();

        // Reset in the third BUSY cycle of SLL by 7 aborts the shift.
        issue(3'd6, 8'h81, 8'h07);
        tick();
        tick();
        chk("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("abort_async_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_result",    32'(result),    32'd0);
        chk("abort_carry",     32'(carry),     32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_stays_idle", 32'(out_valid), 32'd0);
        run_vec('{3'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1}, "post_rst_add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
